// File: rtl/nbit_addsub_serial.sv
// nbit_addsub_serial: digit-serial N-bit adder/subtractor, one K-bit digit per clock, LSB first,
// with valid/ready handshakes and carry/borrow, signed-overflow and zero flags.
module nbit_addsub_serial #(
  parameter int N = 32,
  parameter int K = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         mode,
  input  logic         ci,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] d,
  output logic         co,
  output logic         ovf,
  output logic         zero
);
  localparam int ND = N / K;
  localparam int CW = ND > 1 ? $clog2(ND) : 1;
  localparam logic [CW-1:0] LAST = CW'(ND - 1);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state_q, state_d;
  logic [N-1:0] a_q, a_d, b_q, b_d, d_q, d_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic mode_q, mode_d, chain_q, chain_d, co_q, co_d, ovf_q, ovf_d, zero_q, zero_d;
  logic [K-1:0] bx;
  logic [K:0] sum;
  logic cout;
  // Operands shift right one digit per cycle, so the live digit is always [K-1:0]
  // and on the last digit a_q[K-1]/b_q[K-1] are the original sign bits.
  always_comb begin
    bx = mode_q ? ~b_q[K-1:0] : b_q[K-1:0];
    sum = {1'b0, a_q[K-1:0]} + {1'b0, bx} + {{K{1'b0}}, chain_q ^ mode_q};
    cout = sum[K] ^ mode_q;
    state_d = state_q;
    a_d = a_q;
    b_d = b_q;
    d_d = d_q;
    cnt_d = cnt_q;
    mode_d = mode_q;
    chain_d = chain_q;
    co_d = co_q;
    ovf_d = ovf_q;
    zero_d = zero_q;
    case (state_q)
      IDLE: if (in_valid) begin
        a_d = a;
        b_d = b;
        mode_d = mode;
        chain_d = ci;
        cnt_d = '0;
        state_d = RUN;
      end
      RUN: begin
        a_d = a_q >> K;
        b_d = b_q >> K;
        d_d = (d_q >> K) | (N'(sum[K-1:0]) << (N - K));
        chain_d = cout;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          co_d = cout;
          ovf_d = ((a_q[K-1] ~^ b_q[K-1]) ^ mode_q) & (sum[K-1] ^ a_q[K-1]);
          zero_d = d_d == '0;
          state_d = DONE;
        end
      end
      DONE: state_d = out_ready ? IDLE : DONE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q <= '0;
      b_q <= '0;
      d_q <= '0;
      cnt_q <= '0;
      mode_q <= 1'b0;
      chain_q <= 1'b0;
      co_q <= 1'b0;
      ovf_q <= 1'b0;
      zero_q <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q <= a_d;
      b_q <= b_d;
      d_q <= d_d;
      cnt_q <= cnt_d;
      mode_q <= mode_d;
      chain_q <= chain_d;
      co_q <= co_d;
      ovf_q <= ovf_d;
      zero_q <= zero_d;
    end
  end
  assign in_ready = state_q == IDLE;
  assign out_valid = state_q == DONE;
  assign d = d_q;
  assign co = co_q;
  assign ovf = ovf_q;
  assign zero = zero_q;
endmodule

// File: tb/tb_nbit_addsub_serial.sv
// tb_nbit_addsub_serial: four configurations (8/4, 32/8, 8/8, 16/4) checked against an arithmetic model.
module tb_nbit_addsub_serial;
  logic clk = 1'b0;
  logic [3:0] rst = 4'hf, in_valid = '0, out_ready = '0, mode = '0, ci = '0;
  logic [3:0] in_ready, out_valid, co, ovf, zero;
  logic [31:0] a_drv [4];
  logic [31:0] b_drv [4];
  logic [31:0] dd [4];
  logic [31:0] exp_d [4];
  bit exp_co [4], exp_ovf [4], exp_zero [4], exp_valid [4];
  logic [31:0] last_d [4];
  bit last_co [4], last_ovf [4], last_zero [4];
  int total = 0, passed = 0;
  always #5 clk = ~clk;
  for (genvar g = 0; g < 4; g++) begin : u
    localparam int W = g == 1 ? 32 : g == 3 ? 16 : 8;
    localparam int KD = (g == 0 || g == 3) ? 4 : 8;
    logic [W-1:0] dw;
    nbit_addsub_serial #(.N(W), .K(KD)) dut (
      .clk(clk), .rst(rst[g]), .in_valid(in_valid[g]), .in_ready(in_ready[g]),
      .a(a_drv[g][W-1:0]), .b(b_drv[g][W-1:0]), .mode(mode[g]), .ci(ci[g]),
      .out_valid(out_valid[g]), .out_ready(out_ready[g]), .d(dw),
      .co(co[g]), .ovf(ovf[g]), .zero(zero[g]));
    assign dd[g] = 32'(dw);
  end
  function automatic int nw(int i);
    return i == 1 ? 32 : i == 3 ? 16 : 8;
  endfunction
  function automatic int nd(int i);
    return nw(i) / ((i == 0 || i == 3) ? 4 : 8);
  endfunction
  task automatic chk(string name, logic [63:0] act, logic [63:0] req);
    total++;
    if (act !== req) $display("FAIL %s: got %0h, expected %0h", name, act, req);
    else passed++;
  endtask
  // Reference: plain integer arithmetic; ovf is the true signed result leaving the W-bit range.
  task automatic model(int i, bit md, logic [31:0] aa, logic [31:0] bb, bit cc);
    int w = nw(i);
    longint m = (64'sd1 <<< w) - 1;
    longint ua = longint'(aa) & m;
    longint ub = longint'(bb) & m;
    longint c = longint'(cc);
    longint half = 64'sd1 <<< (w - 1);
    longint r, sa, sb, sr;
    r = md ? ua - ub - c : ua + ub + c;
    sa = ua >= half ? ua - (64'sd1 <<< w) : ua;
    sb = ub >= half ? ub - (64'sd1 <<< w) : ub;
    sr = md ? sa - sb - c : sa + sb + c;
    exp_d[i] = 32'(r & m);
    exp_co[i] = md ? (ua < ub + c) : (r > m);
    exp_ovf[i] = sr > half - 1 || sr < -half;
    exp_zero[i] = (r & m) == 0;
    exp_valid[i] = 1'b1;
  endtask
  always @(negedge clk)
    for (int i = 0; i < 4; i++)
      if (!rst[i] && out_valid[i] === 1'b1) begin
        if (!exp_valid[i]) chk($sformatf("u%0d_spurious_out_valid", i), 1, 0);
        else begin
          chk($sformatf("u%0d_d", i), dd[i], exp_d[i]);
          chk($sformatf("u%0d_co", i), co[i], exp_co[i]);
          chk($sformatf("u%0d_ovf", i), ovf[i], exp_ovf[i]);
          chk($sformatf("u%0d_zero", i), zero[i], exp_zero[i]);
        end
      end
  // Called at posedge+1 with instance i idle; returns at posedge+1 with it idle again.
  task automatic op(int i, bit md, logic [31:0] aa, logic [31:0] bb, bit cc, int hold);
    int n = 0;
    chk($sformatf("u%0d_in_ready_idle", i), in_ready[i], 1);
    a_drv[i] = aa;
    b_drv[i] = bb;
    mode[i] = md;
    ci[i] = cc;
    in_valid[i] = 1'b1;
    model(i, md, aa, bb, cc);
    @(posedge clk); #1;
    in_valid[i] = 1'b0;
    a_drv[i] = $urandom;
    b_drv[i] = $urandom;
    mode[i] = 1'($urandom);
    ci[i] = 1'($urandom);
    while (out_valid[i] !== 1'b1 && n < 64) begin
      @(posedge clk); #1;
      n++;
    end
    chk($sformatf("u%0d_latency", i), n, nd(i));
    last_d[i] = dd[i];
    last_co[i] = co[i];
    last_ovf[i] = ovf[i];
    last_zero[i] = zero[i];
    for (int h = 0; h < hold; h++) begin
      chk($sformatf("u%0d_in_ready_done", i), in_ready[i], 0);
      in_valid[i] = 1'b1;
      a_drv[i] = $urandom;
      b_drv[i] = $urandom;
      @(posedge clk); #1;
      chk($sformatf("u%0d_hold_d", i), dd[i], last_d[i]);
    end
    in_valid[i] = 1'b0;
    out_ready[i] = 1'b1;
    @(posedge clk); #1;
    out_ready[i] = 1'b0;
    exp_valid[i] = 1'b0;
    chk($sformatf("u%0d_out_valid_drop", i), out_valid[i], 0);
    chk($sformatf("u%0d_in_ready_back", i), in_ready[i], 1);
  endtask
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    for (int i = 0; i < 4; i++) begin
      a_drv[i] = '0;
      b_drv[i] = '0;
      exp_valid[i] = 1'b0;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("u%0d_rst_in_ready", i), in_ready[i], 1);
      chk($sformatf("u%0d_rst_out_valid", i), out_valid[i], 0);
      chk($sformatf("u%0d_rst_d", i), dd[i], 0);
      chk($sformatf("u%0d_rst_flags", i), {co[i], ovf[i], zero[i]}, 0);
    end
    rst = '0;
    @(posedge clk); #1;
    op(0, 1, 4, 10, 0, 5);
    chk("sub_4_10", {last_d[0], last_co[0], last_ovf[0], last_zero[0]}, {32'd250, 3'b100});
    op(0, 1, 10, 4, 1, 0);
    chk("sub_10_4_ci", {last_d[0], last_co[0]}, {32'd5, 1'b0});
    op(0, 1, 0, 16, 0, 0);
    chk("sub_0_16", {last_d[0], last_co[0]}, {32'd240, 1'b1});
    op(0, 1, 1, 1, 1, 0);
    chk("sub_1_1_ci", {last_d[0], last_co[0]}, {32'd255, 1'b1});
    op(0, 1, 1, 1, 0, 0);
    chk("sub_1_1", {last_d[0], last_co[0], last_zero[0]}, {32'd0, 2'b01});
    op(0, 0, 200, 100, 0, 0);
    chk("add_200_100", {last_d[0], last_co[0], last_ovf[0]}, {32'd44, 2'b10});
    op(0, 0, 32'h7f, 1, 0, 0);
    chk("add_7f_1", {last_d[0], last_ovf[0]}, {32'h80, 1'b1});
    op(0, 1, 32'h80, 1, 0, 0);
    chk("sub_80_1", {last_d[0], last_ovf[0], last_co[0]}, {32'h7f, 2'b10});
    op(2, 1, 180, 209, 0, 0);
    chk("single_digit_sub", {last_d[2], last_co[2]}, {32'd227, 1'b1});
    a_drv[1] = 32'h1234_5678;
    b_drv[1] = 32'h0fed_cba9;
    mode[1] = 1'b0;
    ci[1] = 1'b0;
    in_valid[1] = 1'b1;
    @(posedge clk); #1;
    in_valid[1] = 1'b0;
    @(posedge clk); #1;
    rst[1] = 1'b1;
    @(posedge clk); #1;
    rst[1] = 1'b0;
    chk("midrun_rst_in_ready", in_ready[1], 1);
    chk("midrun_rst_out_valid", out_valid[1], 0);
    chk("midrun_rst_d", dd[1], 0);
    for (int c = 0; c < 8; c++) begin
      @(posedge clk); #1;
      chk("midrun_rst_no_pulse", out_valid[1], 0);
    end
    op(1, 0, 32'hffff_ffff, 1, 0, 0);
    chk("add_wrap_32", {last_d[1], last_co[1], last_zero[1]}, {32'd0, 2'b11});
    for (int t = 0; t < 200; t++)
      op(3, 1'($urandom), $urandom, $urandom, 1'($urandom), int'($urandom_range(0, 2)));
    for (int t = 0; t < 30; t++)
      for (int i = 0; i < 3; i++)
        op(i, 1'($urandom), $urandom, $urandom, 1'($urandom), int'($urandom_range(0, 1)));
    repeat (2) @(posedge clk);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
